// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan scheduler for an N-digit 7-segment display sharing one decoder.
// Adds tear-free value loading, leading-zero blanking, sign insertion and guard gaps.
module display_scan_ctrl #(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD_CYC      = 500,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  lzb,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  neg,
  output logic                  ready,
  output logic [3:0]            code,
  output logic [N_DIGITS-1:0]   dig_en,
  output logic                  frame_start,
  output logic                  dbg_state
);

  localparam int MAXC  = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int IDX_W = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0]    SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]    GUARD_LAST = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] DIG_OFF    = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [N_DIGITS-1:0] ONE        = {{(N_DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic {S_SHOW = 1'b0, S_GUARD = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  park_q, park_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic                  act_neg_q, act_neg_d, pend_neg_q, pend_neg_d;
  logic                  pend_v_q, pend_v_d, ready_q, ready_d;
  logic [3:0]            code_q, code_d;
  logic [N_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                  fs_q, fs_d;

  logic                  enter, boundary, is_sign, zero_above, blank;
  logic [IDX_W-1:0]      nxt_idx, wrap_idx;
  logic [4*N_DIGITS-1:0] src_val;
  logic                  src_neg;
  logic [3:0]            nib;

  assign wrap_idx = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  // Load handshake: a request is taken on any edge where load=1 and ready=1;
  // ready then stays low until the next frame boundary moves pending to active.
  always_comb begin
    state_d    = state_q;
    park_d     = park_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    act_val_d  = act_val_q;
    act_neg_d  = act_neg_q;
    pend_val_d = pend_val_q;
    pend_neg_d = pend_neg_q;
    pend_v_d   = pend_v_q;
    ready_d    = ready_q;
    code_d     = code_q;
    dig_en_d   = dig_en_q;
    fs_d       = 1'b0;
    enter      = 1'b0;
    nxt_idx    = '0;
    zero_above = 1'b1;

    if (!en) begin
      state_d  = S_SHOW;
      park_d   = 1'b1;
      idx_d    = '0;
      cnt_d    = '0;
      dig_en_d = DIG_OFF;
    end else if (park_q) begin
      enter  = 1'b1;
      park_d = 1'b0;
    end else if (state_q == S_SHOW) begin
      if (cnt_q == SHOW_LAST) begin
        if (GUARD_CYC == 0) begin
          enter   = 1'b1;
          nxt_idx = wrap_idx;
        end else begin
          state_d  = S_GUARD;
          cnt_d    = '0;
          dig_en_d = DIG_OFF;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (cnt_q == GUARD_LAST) begin
        enter   = 1'b1;
        nxt_idx = wrap_idx;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    boundary = enter && (nxt_idx == '0);
    // The value made active at this boundary must already drive digit 0.
    src_val  = (boundary && pend_v_q) ? pend_val_q : act_val_q;
    src_neg  = (boundary && pend_v_q) ? pend_neg_q : act_neg_q;
    nib      = src_val[4*int'(nxt_idx) +: 4];
    is_sign  = src_neg && (nxt_idx == IDX_LAST);
    for (int j = 0; j < N_DIGITS; j++) begin
      if (j >= int'(nxt_idx) && !(src_neg && j == N_DIGITS-1) && src_val[4*j +: 4] != 4'd0)
        zero_above = 1'b0;
    end
    blank = lzb && (nxt_idx != '0) && !is_sign && zero_above;

    if (enter) begin
      state_d  = S_SHOW;
      idx_d    = nxt_idx;
      cnt_d    = '0;
      code_d   = (is_sign || nib > 4'd11) ? 4'b1010 : nib;
      dig_en_d = blank ? DIG_OFF : ((ONE << nxt_idx) ^ DIG_OFF);
    end

    if (boundary) begin
      fs_d = 1'b1;
      if (pend_v_q) begin
        act_val_d = pend_val_q;
        act_neg_d = pend_neg_q;
        pend_v_d  = 1'b0;
        ready_d   = 1'b1;
      end
    end

    if (load && ready_q) begin
      pend_val_d = value;
      pend_neg_d = neg;
      pend_v_d   = 1'b1;
      ready_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_SHOW;
      park_q     <= 1'b1;
      idx_q      <= '0;
      cnt_q      <= '0;
      act_val_q  <= '0;
      act_neg_q  <= 1'b0;
      pend_val_q <= '0;
      pend_neg_q <= 1'b0;
      pend_v_q   <= 1'b0;
      ready_q    <= 1'b1;
      code_q     <= 4'b0000;
      dig_en_q   <= DIG_OFF;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      park_q     <= park_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      act_val_q  <= act_val_d;
      act_neg_q  <= act_neg_d;
      pend_val_q <= pend_val_d;
      pend_neg_q <= pend_neg_d;
      pend_v_q   <= pend_v_d;
      ready_q    <= ready_d;
      code_q     <= code_d;
      dig_en_q   <= dig_en_d;
      fs_q       <= fs_d;
    end
  end

  assign ready       = ready_q;
  assign code        = code_q;
  assign dig_en      = dig_en_q;
  assign frame_start = fs_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with N=4, SCAN_DIV=4, GUARD_CYC=1, active-low enables.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, en, lzb, load, neg;
  logic [15:0] value;
  logic        ready, frame_start, dbg_state;
  logic [3:0]  code, dig_en;

  int n_checks = 0;
  int n_errors = 0;

  display_scan_ctrl #(
    .N_DIGITS(4), .SCAN_DIV(4), .GUARD_CYC(1), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .lzb(lzb), .load(load), .value(value),
    .neg(neg), .ready(ready), .code(code), .dig_en(dig_en),
    .frame_start(frame_start), .dbg_state(dbg_state)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame is 4 slots of 5 cycles: 4 SHOW cycles then 1 GUARD cycle.
  function automatic logic [3:0] exp_dig(input int k, input logic [3:0] lit);
    int s = k / 5;
    int p = k % 5;
    if (p < 4 && lit[s]) return ~(4'b0001 << s);
    return 4'hF;
  endfunction

  task automatic sync_frame(input string tag);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (frame_start === 1'b1) got = 1;
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL %s_sync: frame_start=0 after 40 cycles, required 1", tag);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; lzb = 1'b0; load = 1'b0; neg = 1'b0; value = 16'h0;
    tick(); tick();
    n_checks++;
    if (ready !== 1'b1 || code !== 4'h0 || dig_en !== 4'hF || frame_start !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_vals: ready=%b code=%h dig_en=%b fs=%b, required 1 0 1111 0",
               ready, code, dig_en, frame_start);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (frame_start !== 1'b1 || dig_en !== 4'b1110) begin
      n_errors++;
      $display("FAIL reset_first_frame: fs=%b dig_en=%b, required 1 1110", frame_start, dig_en);
    end
  endtask

  task automatic test_scan();
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (dig_en !== exp_dig(k, 4'hF) || frame_start !== (k == 0) || code !== 4'h0) begin
        n_errors++;
        $display("FAIL scan k=%0d: dig_en=%b fs=%b code=%h, required %b %b 0",
                 k, dig_en, frame_start, code, exp_dig(k, 4'hF), (k == 0));
      end
    end
    tick();
    n_checks++;
    if (frame_start !== 1'b1 || dig_en !== 4'b1110) begin
      n_errors++;
      $display("FAIL scan_wrap: fs=%b dig_en=%b, required 1 1110", frame_start, dig_en);
    end
  endtask

  task automatic test_lzb_idle();
    lzb = 1'b1;
    sync_frame("lzb_idle");
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (dig_en !== exp_dig(k, 4'b0001)) begin
        n_errors++;
        $display("FAIL lzb_idle k=%0d: dig_en=%b, required %b", k, dig_en, exp_dig(k, 4'b0001));
      end
    end
    lzb = 1'b0;
  endtask

  task automatic test_load();
    bit got = 0;
    logic [15:0] codes = 16'h1234;
    sync_frame("load");
    repeat (6) tick();
    value = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if (ready !== 1'b0) begin
      n_errors++;
      $display("FAIL load_ready_low: ready=%b, required 0", ready);
    end
    value = 16'h9999; load = 1'b1;
    tick();
    load = 1'b0; value = 16'h0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (frame_start === 1'b1) got = 1;
      else begin
        n_checks++;
        if (code !== 4'h0 || ready !== 1'b0) begin
          n_errors++;
          $display("FAIL load_pending i=%0d: code=%h ready=%b, required 0 0", i, code, ready);
        end
        tick();
      end
    end
    n_checks++;
    if (!got || ready !== 1'b1) begin
      n_errors++;
      $display("FAIL load_boundary: fs_seen=%b ready=%b, required 1 1", got, ready);
    end
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (dig_en !== exp_dig(k, 4'hF) || code !== codes[4*(k/5) +: 4]) begin
        n_errors++;
        $display("FAIL load_frame k=%0d: dig_en=%b code=%h, required %b %h",
                 k, dig_en, code, exp_dig(k, 4'hF), codes[4*(k/5) +: 4]);
      end
    end
  endtask

  task automatic test_lzb_value();
    logic [15:0] codes = 16'h0052;
    value = 16'h0052; load = 1'b1; lzb = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if (ready !== 1'b0) begin
      n_errors++;
      $display("FAIL lzbv_ready_low: ready=%b, required 0", ready);
    end
    sync_frame("lzbv");
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (dig_en !== exp_dig(k, 4'b0011) || (k < 10 && code !== codes[4*(k/5) +: 4])) begin
        n_errors++;
        $display("FAIL lzb_on k=%0d: dig_en=%b code=%h, required %b %h",
                 k, dig_en, code, exp_dig(k, 4'b0011), codes[4*(k/5) +: 4]);
      end
    end
    lzb = 1'b0;
    sync_frame("lzb_off");
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (dig_en !== exp_dig(k, 4'hF) || code !== codes[4*(k/5) +: 4]) begin
        n_errors++;
        $display("FAIL lzb_off k=%0d: dig_en=%b code=%h, required %b %h",
                 k, dig_en, code, exp_dig(k, 4'hF), codes[4*(k/5) +: 4]);
      end
    end
  endtask

  task automatic test_neg();
    logic [15:0] codes = 16'hA0A7;
    value = 16'h00F7; neg = 1'b1; lzb = 1'b1; load = 1'b1;
    tick();
    load = 1'b0; neg = 1'b0; value = 16'h0;
    sync_frame("neg");
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (dig_en !== exp_dig(k, 4'b1011) ||
          ((k / 5) != 2 && code !== codes[4*(k/5) +: 4])) begin
        n_errors++;
        $display("FAIL neg k=%0d: dig_en=%b code=%h, required %b %h",
                 k, dig_en, code, exp_dig(k, 4'b1011), codes[4*(k/5) +: 4]);
      end
    end
    lzb = 1'b0;
  endtask

  task automatic test_reset_mid();
    sync_frame("rst_mid");
    repeat (11) tick();
    n_checks++;
    if (dig_en !== 4'b1011) begin
      n_errors++;
      $display("FAIL rst_mid_pre: dig_en=%b, required 1011", dig_en);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dig_en !== 4'hF || code !== 4'h0 || frame_start !== 1'b0 || ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_async: dig_en=%b code=%h fs=%b ready=%b, required 1111 0 0 1",
               dig_en, code, frame_start, ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (frame_start !== 1'b1 || dig_en !== 4'b1110 || code !== 4'h0) begin
      n_errors++;
      $display("FAIL rst_mid_restart: fs=%b dig_en=%b code=%h, required 1 1110 0",
               frame_start, dig_en, code);
    end
  endtask

  task automatic test_en();
    repeat (6) tick();
    en = 1'b0; value = 16'h0008; load = 1'b1;
    tick();
    load = 1'b0; value = 16'h0;
    n_checks++;
    if (dig_en !== 4'hF || frame_start !== 1'b0 || ready !== 1'b0) begin
      n_errors++;
      $display("FAIL en_off: dig_en=%b fs=%b ready=%b, required 1111 0 0", dig_en, frame_start, ready);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++;
      if (dig_en !== 4'hF || frame_start !== 1'b0) begin
        n_errors++;
        $display("FAIL en_hold i=%0d: dig_en=%b fs=%b, required 1111 0", i, dig_en, frame_start);
      end
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (frame_start !== 1'b1 || dig_en !== 4'b1110 || code !== 4'h8 || ready !== 1'b1) begin
      n_errors++;
      $display("FAIL en_restart: fs=%b dig_en=%b code=%h ready=%b, required 1 1110 8 1",
               frame_start, dig_en, code, ready);
    end
    for (int i = 1; i < 5; i++) begin
      tick();
      n_checks++;
      if (dig_en !== ((i < 4) ? 4'b1110 : 4'hF) || frame_start !== 1'b0) begin
        n_errors++;
        $display("FAIL en_digit0 i=%0d: dig_en=%b fs=%b, required %b 0",
                 i, dig_en, frame_start, (i < 4) ? 4'b1110 : 4'hF);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lzb_idle();
    test_load();
    test_lzb_value();
    test_neg();
    test_reset_mid();
    test_en();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
